// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants and the 10-bit coordinate type
// Revision    : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int unsigned C_COORD_W  = 10;

    localparam int unsigned C_H_ACTIVE = 640;
    localparam int unsigned C_H_FP     = 16;
    localparam int unsigned C_H_SYNC   = 96;
    localparam int unsigned C_H_BP     = 48;
    localparam int unsigned C_V_ACTIVE = 480;
    localparam int unsigned C_V_FP     = 10;
    localparam int unsigned C_V_SYNC   = 2;
    localparam int unsigned C_V_BP     = 33;

    localparam int unsigned C_H_TOTAL      = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;
    localparam int unsigned C_V_TOTAL      = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;
    localparam int unsigned C_H_SYNC_START = C_H_ACTIVE + C_H_FP;
    localparam int unsigned C_H_SYNC_END   = C_H_SYNC_START + C_H_SYNC;
    localparam int unsigned C_V_SYNC_START = C_V_ACTIVE + C_V_FP;
    localparam int unsigned C_V_SYNC_END   = C_V_SYNC_START + C_V_SYNC;

    typedef logic [C_COORD_W-1:0] coord_t;

    // Half-open interval test: lo <= v < hi
    function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_cnt
// Description : Wrap counter 0..TOTAL-1 for one screen axis
// Revision    : 1.0
// ============================================================================
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = C_H_TOTAL
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   inc,
    input  logic   clr,
    output coord_t cnt_o,
    output logic   wrap
);

    localparam coord_t C_LAST = coord_t'(TOTAL - 1);

    coord_t r_cnt;

    assign wrap  = inc && (r_cnt == C_LAST);
    assign cnt_o = r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA sync/position generator with registered outputs
// Revision    : 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = C_H_ACTIVE,
    parameter int unsigned H_FP     = C_H_FP,
    parameter int unsigned H_SYNC   = C_H_SYNC,
    parameter int unsigned H_BP     = C_H_BP,
    parameter int unsigned V_ACTIVE = C_V_ACTIVE,
    parameter int unsigned V_FP     = C_V_FP,
    parameter int unsigned V_SYNC   = C_V_SYNC,
    parameter int unsigned V_BP     = C_V_BP
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       disp_active,
    output logic [9:0] xcol_o,
    output logic [9:0] yrow_o,
    output logic       pix_tick_o,
    output logic       frame_start_o
);

    localparam int unsigned C_HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned C_VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned C_HS0 = H_ACTIVE + H_FP;
    localparam int unsigned C_HS1 = C_HS0 + H_SYNC;
    localparam int unsigned C_VS0 = V_ACTIVE + V_FP;
    localparam int unsigned C_VS1 = C_VS0 + V_SYNC;

    localparam int unsigned     C_PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(CLK_DIV - 1);

    if (C_HT >= 1024 || C_VT >= 1024 || CLK_DIV < 1) begin : g_param_check
        $error("vga_timing_gen: totals must be below 1024 and CLK_DIV at least 1");
    end

    logic [C_PW-1:0] r_presc;
    logic            w_tick;
    logic            w_h_wrap;
    coord_t          w_h_nxt;
    coord_t          w_v_nxt;

    coord_t r_xcol;
    coord_t r_yrow;
    logic   r_disp;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_tick;
    logic   r_fs;

    assign w_tick = en_i && (r_presc == C_PRESC_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (!en_i || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    vga_axis_cnt #(.TOTAL(C_HT)) u_h_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (w_tick),
        .clr    (!en_i),
        .cnt_o  (w_h_nxt),
        .wrap   (w_h_wrap)
    );

    // Vertical wrap is implied by both axes wrapping together; not needed here
    vga_axis_cnt #(.TOTAL(C_VT)) u_v_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (w_h_wrap),
        .clr    (!en_i),
        .cnt_o  (w_v_nxt),
        .wrap   ()
    );

    // Outputs show the position that the counters held when the tick fired
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_xcol  <= '0;
            r_yrow  <= '0;
            r_disp  <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_tick  <= 1'b0;
            r_fs    <= 1'b0;
        end else if (!en_i) begin
            r_xcol  <= '0;
            r_yrow  <= '0;
            r_disp  <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_tick  <= 1'b0;
            r_fs    <= 1'b0;
        end else if (w_tick) begin
            r_xcol  <= w_h_nxt;
            r_yrow  <= w_v_nxt;
            r_disp  <= (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
            r_hsync <= !in_range(w_h_nxt, C_HS0, C_HS1);
            r_vsync <= !in_range(w_v_nxt, C_VS0, C_VS1);
            r_tick  <= 1'b1;
            r_fs    <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end else begin
            r_tick  <= 1'b0;
            r_fs    <= 1'b0;
        end
    end

    assign xcol_o        = r_xcol;
    assign yrow_o        = r_yrow;
    assign disp_active   = r_disp;
    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign pix_tick_o    = r_tick;
    assign frame_start_o = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench on reduced 14x7 timing, CLK_DIV 4 and 1
// Revision    : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b1;
    logic       en_i   = 1'b1;

    logic       hsync_o, vsync_o, disp_active, pix_tick_o, frame_start_o;
    logic [9:0] xcol_o, yrow_o;
    logic       hs1, vs1, da1, tick1, fs1;
    logic [9:0] x1, y1;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .disp_active(disp_active),
        .xcol_o(xcol_o), .yrow_o(yrow_o),
        .pix_tick_o(pix_tick_o), .frame_start_o(frame_start_o)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i),
        .hsync_o(hs1), .vsync_o(vs1), .disp_active(da1),
        .xcol_o(x1), .yrow_o(y1),
        .pix_tick_o(tick1), .frame_start_o(fs1)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       da;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    exp_t a_m;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   fs_last = -1;
    int   fs_period = 0;
    int   da_cnt = 0;
    int   da_frame = 0;

    // 14x7 frame: visible 8x4, hsync low at x 10..11, vsync low at y 5
    function automatic exp_t model(int x, int y);
        exp_t e;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.da = (x < 8) && (y < 4);
        e.hs = !(x == 10 || x == 11);
        e.vs = (y != 5);
        e.fs = (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic push_run(int x0, int y0, int n);
        int x = x0;
        int y = y0;
        repeat (n) begin
            q.push_back(model(x, y));
            x++;
            if (x == 14) begin
                x = 0;
                y++;
                if (y == 7) y = 0;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic lat(string name, int exp);
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!pix_tick_o && n < 20);
        check(name, n, exp);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        check("drain", q.size(), 0);
        if (q.size() != 0) q.delete();
    endtask

    task automatic check_idle(string tag);
        check({tag, "_x"},    int'(xcol_o), 0);
        check({tag, "_y"},    int'(yrow_o), 0);
        check({tag, "_da"},   int'(disp_active), 0);
        check({tag, "_hs"},   int'(hsync_o), 1);
        check({tag, "_vs"},   int'(vsync_o), 1);
        check({tag, "_tick"}, int'(pix_tick_o), 0);
        check({tag, "_fs"},   int'(frame_start_o), 0);
    endtask

    task automatic check_fast();
        int ticks = 0;
        int per = 0;
        int fs_l = -1;
        int maxx = 0;
        int wraps = 0;
        int prv = 0;
        @(negedge clk); #1;
        check("fast_first_fs", int'(fs1), 1);
        check("fast_first_x", int'(x1), 0);
        for (int i = 0; i < 200; i++) begin
            if (tick1) ticks++;
            if (fs1) begin
                if (fs_l >= 0) per = i - fs_l;
                fs_l = i;
            end
            if (int'(x1) > maxx) maxx = int'(x1);
            if (i > 0 && prv == 13 && x1 == 10'd0) wraps++;
            prv = int'(x1);
            @(negedge clk); #1;
        end
        check("fast_ticks", ticks, 200);
        check("fast_frame_period", per, 98);
        check("fast_max_x", maxx, 13);
        check("fast_x_wraps", wraps, 14);
    endtask

    // Monitor: every output update is popped against the scoreboard
    always @(negedge clk) begin
        cyc++;
        if (pix_tick_o) begin
            if (q.size() == 0) begin
                check("unexpected_tick", int'(pix_tick_o), 0);
            end else begin
                e_m = q.pop_front();
                a_m = {xcol_o, yrow_o, disp_active, hsync_o, vsync_o, frame_start_o};
                n_chk++;
                if (a_m == e_m) n_pass++;
                else $display("FAIL tick_out: got x=%0d y=%0d da=%b hs=%b vs=%b fs=%b, expected x=%0d y=%0d da=%b hs=%b vs=%b fs=%b",
                              a_m.x, a_m.y, a_m.da, a_m.hs, a_m.vs, a_m.fs,
                              e_m.x, e_m.y, e_m.da, e_m.hs, e_m.vs, e_m.fs);
            end
            if (frame_start_o) begin
                if (fs_last >= 0) fs_period = cyc - fs_last;
                fs_last  = cyc;
                da_frame = da_cnt;
                da_cnt   = 0;
            end
            if (disp_active) da_cnt++;
        end else begin
            check("fs_hold_low", int'(frame_start_o), 0);
        end
    end

    initial begin
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_idle("reset");

        // One full frame plus the next (0,0)
        push_run(0, 0, 99);
        rst_ni = 1'b1;
        fork
            begin
                lat("lat_reset", 4);
                drain(600);
            end
            check_fast();
        join
        check("frame_period", fs_period, 392);
        check("disp_ticks_per_frame", da_frame, 32);

        // Run on to (9,2), then drop en_i just before the next tick edge
        push_run(1, 0, 37);
        drain(200);
        repeat (3) @(negedge clk);
        #2;
        en_i = 1'b0;
        @(negedge clk); #2;
        check_idle("en_drop");

        push_run(0, 0, 16);
        en_i = 1'b1;
        lat("lat_enable", 4);
        drain(100);

        // Asynchronous reset while showing (1,1), away from any clock edge
        rst_ni = 1'b0;
        #1;
        check("async_x", int'(xcol_o), 0);
        check("async_y", int'(yrow_o), 0);
        check("async_da", int'(disp_active), 0);
        check("async_tick", int'(pix_tick_o), 0);
        repeat (2) @(negedge clk);
        #2;
        push_run(0, 0, 20);
        rst_ni = 1'b1;
        lat("lat_rst_release", 4);
        drain(120);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk_i cycles per pixel (100 MHz clk_i to 25 MHz pixel rate); legal values are 1 or greater.
REQ-002 SHALL have parameter H_ACTIVE/H_FP/H_SYNC/H_BP, default 640/16/96/48: horizontal timing, in pixels.
REQ-003 SHALL have parameter V_ACTIVE/V_FP/V_SYNC/V_BP, default 480/10/2/33: vertical timing, in lines.
REQ-004 SHALL have port clk_i, input, width 1: the single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en_i, input, width 1: run enable.
REQ-007 SHALL have port hsync_o, output, width 1: horizontal sync, active-low.
REQ-008 SHALL have port vsync_o, output, width 1: vertical sync, active-low.
REQ-009 SHALL have port disp_active, output, width 1: high while the current pixel is inside the visible area.
REQ-010 SHALL have port xcol_o, output, width 10: current column, 0..H_TOTAL-1.
REQ-011 SHALL have port yrow_o, output, width 10: current row, 0..V_TOTAL-1.
REQ-012 SHALL have port pix_tick_o, output, width 1: one-clk_i strobe in the cycle in which the position outputs change.
REQ-013 SHALL have port frame_start_o, output, width 1: one-clk_i strobe when the outputs show position (0,0).

Function
REQ-014 SHALL compute H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL likewise (525 by default).
REQ-015 SHALL run a prescaler 0..CLK_DIV-1 while en_i=1; the internal tick is asserted when the prescaler equals CLK_DIV-1; with CLK_DIV=1 the tick is asserted every cycle.
REQ-016 SHALL hold next-position counters h_nxt and v_nxt, both 0 after reset.
REQ-017 On each tick, SHALL load every output register from the decode of (h_nxt, v_nxt), then advance the counters.
REQ-018 Counter advance SHALL be: h_nxt wraps from H_TOTAL-1 to 0; v_nxt increments only on that wrap; v_nxt wraps from V_TOTAL-1 to 0 when both counters wrap in the same tick.
REQ-019 The decode SHALL be: xcol_o=h, yrow_o=v.
REQ-020 The decode SHALL be: disp_active = (h<H_ACTIVE) and (v<V_ACTIVE).
REQ-021 The decode SHALL be: hsync_o=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-022 The decode SHALL be: vsync_o=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-023 The decode SHALL be: frame_start_o=1 iff h=0 and v=0.
REQ-024 SHALL register pix_tick_o as the tick, so it is high exactly in the cycles following an output update.
REQ-025 frame_start_o SHALL be high for that one cycle only and low otherwise.
REQ-026 All outputs SHALL hold their values between ticks; no output is driven by combinational logic from the counters.
REQ-027 Latency: the first tick after reset or after en_i rises SHALL occur CLK_DIV cycles after that event, and SHALL present (0,0) with disp_active=1 and frame_start_o=1.
REQ-028 en_i=0 SHALL synchronously clear the prescaler and counters and drive all outputs to their reset values.
REQ-029 en_i=0 SHALL take priority over a coincident tick.
REQ-030 Arithmetic SHALL use 10-bit unsigned counters; parameter sums of 1024 or more are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-031 While rst_ni=0, asynchronously: xcol_o=0, yrow_o=0, disp_active=0, hsync_o=1, vsync_o=1, pix_tick_o=0, frame_start_o=0, and the prescaler and counters are 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the next frame SHALL start at (0,0) per REQ-027.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants, the total/sync-boundary localparams, and the 10-bit coordinate typedef.
REQ-034 Sub-module vga_axis_cnt SHALL provide a parameterised wrap counter with inputs inc and clr and output wrap; it is instantiated once for horizontal and once for vertical.

Verification
REQ-035 Reset release with en_i=1 and defaults: first pix_tick_o at clk_i cycle 4 after release, with xcol_o=0, yrow_o=0, disp_active=1, frame_start_o=1.
REQ-036 Run one line: hsync_o is low for exactly 96 ticks, starting when xcol_o=656; disp_active falls when xcol_o=640; xcol_o returns 0 after 799 while yrow_o increments.
REQ-037 Run one full frame: 420000 ticks (1680000 clk_i) between frame_start_o pulses; vsync_o low only for yrow_o 490..491; disp_active high for 307200 ticks.
REQ-038 Drop en_i at xcol_o=700, yrow_o=300, coincident with a tick: on the next clk_i all outputs are at reset values; after en_i rises, (0,0) appears after 4 cycles.
REQ-039 Pulse rst_ni low asynchronously at xcol_o=100, yrow_o=50, mid-clock: outputs clear immediately without waiting for a clock edge; after release, REQ-035 holds.
REQ-040 With CLK_DIV=1 and H/V timing 8/2/2/2 and 4/1/1/1: pix_tick_o is high every cycle; xcol_o wraps 13 to 0; the frame period is 14x7=98 cycles.
